// File: rtl/mem_access_unit_if.sv
// Request handshake plus memory-port bundle shared by the control path,
// mem_access_unit and the unified instruction/data memory.
interface mem_access_unit_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          REQ_VALID;
  logic          REQ_READY;
  logic [1:0]    REQ_OP;
  logic [AW-1:0] REQ_ADDR;
  logic [DW-1:0] REQ_WDATA;
  logic          DONE;
  logic          ERR;
  logic [AW-1:0] MRA;
  logic          MWE;
  logic [DW-1:0] MWD;
  logic [DW-1:0] MRD;

  // Requester and memory side: issues requests and returns read data
  modport master (
    output REQ_VALID, REQ_OP, REQ_ADDR, REQ_WDATA, MRD,
    input  REQ_READY, DONE, ERR, MRA, MWE, MWD
  );

  // Access unit side
  modport slave (
    input  REQ_VALID, REQ_OP, REQ_ADDR, REQ_WDATA, MRD,
    output REQ_READY, DONE, ERR, MRA, MWE, MWD
  );
endinterface

// File: rtl/mem_access_unit.sv
// Requester-side sequencer for the unified memory: fetch/load/store over a
// valid/ready handshake, honouring the memory's one-cycle registered read.
module mem_access_unit #(
  parameter int AW = 9,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  mem_access_unit_if.slave bus,
  output logic [DW-1:0]    IR,
  output logic [DW-1:0]    MDR,
  output logic [CW-1:0]    ACC_CNT
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  logic [2:0]    state_r;
  logic [2:0]    next_state_s;
  logic [1:0]    op_r;
  logic          accept_s;
  logic          ready_r;
  logic          done_r;
  logic          err_r;
  logic          mwe_r;
  logic [AW-1:0] mra_r;
  logic [DW-1:0] mwd_r;
  logic [DW-1:0] ir_r;
  logic [DW-1:0] mdr_r;
  logic [CW-1:0] acc_cnt_r;

  assign accept_s = (state_r == IDLE) && bus.REQ_VALID;

  // Next-state decode for the access sequence
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (bus.REQ_VALID) begin
          case (bus.REQ_OP)
            OP_FETCH, OP_LOAD: next_state_s = RD;
            OP_STORE:          next_state_s = WR;
            default:           next_state_s = RESP;
          endcase
        end else begin
          next_state_s = IDLE;
        end
      end
      RD:      next_state_s = CAP;
      CAP:     next_state_s = RESP;
      WR:      next_state_s = RESP;
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register and registered handshake/status outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      op_r    <= OP_FETCH;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      mwe_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s == IDLE);
      done_r  <= (next_state_s == RESP);
      // Only a reserved op reaches RESP straight from IDLE
      err_r   <= accept_s && (bus.REQ_OP == OP_RSVD);
      mwe_r   <= (next_state_s == WR);
      if (accept_s) begin
        op_r <= bus.REQ_OP;
      end
    end
  end

  // Memory address and write-data registers; held outside active states
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mra_r <= {AW{1'b0}};
      mwd_r <= {DW{1'b0}};
    end else begin
      if (accept_s && (bus.REQ_OP != OP_RSVD)) begin
        mra_r <= bus.REQ_ADDR;
      end
      if (accept_s && (bus.REQ_OP == OP_STORE)) begin
        mwd_r <= bus.REQ_WDATA;
      end
    end
  end

  // Read-data capture into IR/MDR and completed-access counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ir_r      <= {DW{1'b0}};
      mdr_r     <= {DW{1'b0}};
      acc_cnt_r <= {CW{1'b0}};
    end else begin
      if (state_r == CAP) begin
        if (op_r == OP_FETCH) begin
          ir_r <= bus.MRD;
        end else begin
          mdr_r <= bus.MRD;
        end
      end
      if ((state_r == RESP) && (op_r != OP_RSVD)) begin
        acc_cnt_r <= acc_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.REQ_READY = ready_r;
  assign bus.DONE      = done_r;
  assign bus.ERR       = err_r;
  assign bus.MRA       = mra_r;
  assign bus.MWE       = mwe_r;
  assign bus.MWD       = mwd_r;
  assign IR            = ir_r;
  assign MDR           = mdr_r;
  assign ACC_CNT       = acc_cnt_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: memory model, transaction-level
// reference model, directed spec scenarios plus randomized requests.
module tb_mem_access_unit;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [DW-1:0] IR, MDR, IR2, MDR2;
  logic [CW-1:0] ACC_CNT;
  logic [2:0]    ACC_CNT2;

  mem_access_unit_if #(.AW(AW), .DW(DW)) bus ();
  mem_access_unit_if #(.AW(AW), .DW(DW)) bus2 ();

  mem_access_unit #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus.slave), .IR(IR), .MDR(MDR), .ACC_CNT(ACC_CNT)
  );

  // Narrow-counter instance used to exercise the wrap in a few accesses
  mem_access_unit #(.AW(AW), .DW(DW), .CW(3)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus2.slave), .IR(IR2), .MDR(MDR2), .ACC_CNT(ACC_CNT2)
  );

  always #5 CLK = ~CLK;

  // Unified memory with registered read, plus a backdoor preload port
  logic [DW-1:0] mem [0:511];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  always @(posedge CLK) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.MWE) mem[bus.MRA] <= bus.MWD;
    bus.MRD <= mem[bus.MRA];
  end

  assign bus2.MRD = 32'h0000_0000;

  // Transaction-level reference model
  logic [DW-1:0] ref_mem [0:511];
  logic [DW-1:0] ref_ir, ref_mdr, ref_mwd;
  logic [AW-1:0] ref_mra;
  logic [CW-1:0] ref_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic model_reset();
    ref_ir = '0; ref_mdr = '0; ref_mwd = '0; ref_mra = '0; ref_cnt = '0;
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge CLK);
    bd_we = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
    @(negedge CLK);
    bd_we = 1'b0;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 512; i++) begin
      @(negedge CLK);
      bd_we = 1'b1; bd_addr = 9'(i); bd_data = $urandom; ref_mem[i] = bd_data;
    end
    @(negedge CLK);
    bd_we = 1'b0;
  endtask

  // One complete request with per-cycle observation of the response timing
  task automatic run_req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int lat, wait_n, done_k, done_n, err_k, mwe_n, mwe_k, rdy_k;
    logic [AW-1:0] mra1;
    logic [DW-1:0] mwd1;
    lat = (op == 2'b10) ? 2 : ((op == 2'b11) ? 1 : 3);
    wait_n = 0;
    @(negedge CLK);
    while (!bus.REQ_READY && wait_n < 20) begin @(negedge CLK); wait_n++; end
    checks++;
    if (bus.REQ_READY !== 1'b1) begin
      errors++; $display("FAIL ready_wait: REQ_READY=%b after %0d cycles, expected 1", bus.REQ_READY, wait_n);
    end
    bus.REQ_VALID = 1'b1; bus.REQ_OP = op; bus.REQ_ADDR = addr; bus.REQ_WDATA = wd;
    done_k = 0; done_n = 0; err_k = 0; mwe_n = 0; mwe_k = 0; rdy_k = 0; mra1 = '0; mwd1 = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        mra1 = bus.MRA; mwd1 = bus.MWD;
        bus.REQ_VALID = 1'b0; bus.REQ_ADDR = 9'($urandom); bus.REQ_WDATA = $urandom;
      end
      if (bus.DONE === 1'b1) begin done_n++; if (done_k == 0) done_k = k; end
      if (bus.ERR === 1'b1 && err_k == 0) err_k = k;
      if (bus.MWE === 1'b1) begin mwe_n++; mwe_k = k; end
      if (bus.REQ_READY === 1'b1 && rdy_k == 0) rdy_k = k;
    end
    case (op)
      2'b00: begin ref_ir = ref_mem[addr]; ref_mra = addr; ref_cnt = ref_cnt + 16'd1; end
      2'b01: begin ref_mdr = ref_mem[addr]; ref_mra = addr; ref_cnt = ref_cnt + 16'd1; end
      2'b10: begin ref_mem[addr] = wd; ref_mra = addr; ref_mwd = wd; ref_cnt = ref_cnt + 16'd1; end
      default: ;
    endcase
    checks++;
    if (done_k != lat || done_n != 1) begin
      errors++; $display("FAIL done op=%0d addr=%0d: cycle %0d count %0d, expected cycle %0d count 1", op, addr, done_k, done_n, lat);
    end
    checks++;
    if (err_k != ((op == 2'b11) ? 1 : 0)) begin
      errors++; $display("FAIL err op=%0d: ERR cycle %0d, expected %0d", op, err_k, (op == 2'b11) ? 1 : 0);
    end
    checks++;
    if (rdy_k != lat + 1) begin
      errors++; $display("FAIL ready_return op=%0d: cycle %0d, expected %0d", op, rdy_k, lat + 1);
    end
    checks++;
    if (mwe_n != ((op == 2'b10) ? 1 : 0) || mwe_k != ((op == 2'b10) ? 1 : 0)) begin
      errors++; $display("FAIL mwe op=%0d: %0d cycles last at %0d, expected %0d", op, mwe_n, mwe_k, (op == 2'b10) ? 1 : 0);
    end
    checks++;
    if (mra1 !== ref_mra || mwd1 !== ref_mwd) begin
      errors++; $display("FAIL mem_port op=%0d: MRA=%0d MWD=%h, expected MRA=%0d MWD=%h", op, mra1, mwd1, ref_mra, ref_mwd);
    end
    checks++;
    if (IR !== ref_ir || MDR !== ref_mdr) begin
      errors++; $display("FAIL regs op=%0d addr=%0d: IR=%h MDR=%h, expected IR=%h MDR=%h", op, addr, IR, MDR, ref_ir, ref_mdr);
    end
    checks++;
    if (ACC_CNT !== ref_cnt) begin
      errors++; $display("FAIL acc_cnt op=%0d: got %0d, expected %0d", op, ACC_CNT, ref_cnt);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    bus.REQ_VALID = 1'b1; bus.REQ_OP = 2'b10; bus.REQ_ADDR = 9'd3; bus.REQ_WDATA = 32'h1234_5678;
    bus2.REQ_VALID = 1'b0; bus2.REQ_OP = 2'b00; bus2.REQ_ADDR = 9'd0; bus2.REQ_WDATA = 32'h0;
    model_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if (bus.REQ_READY !== 1'b1 || bus.DONE !== 1'b0 || bus.ERR !== 1'b0 || bus.MWE !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: READY=%b DONE=%b ERR=%b MWE=%b, expected 1 0 0 0", bus.REQ_READY, bus.DONE, bus.ERR, bus.MWE);
    end
    checks++;
    if (IR !== 32'h0 || MDR !== 32'h0 || ACC_CNT !== 16'h0 || bus.MRA !== 9'h0 || bus.MWD !== 32'h0) begin
      errors++; $display("FAIL reset_regs: IR=%h MDR=%h CNT=%h MRA=%h MWD=%h, expected all 0", IR, MDR, ACC_CNT, bus.MRA, bus.MWD);
    end
    bus.REQ_VALID = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_fetch();
    bd_write(9'd20, 32'd17);
    run_req(2'b00, 9'd20, 32'h0);
    checks++;
    if (IR !== 32'h0000_0011) begin
      errors++; $display("FAIL fetch_ir: IR=%h, expected 00000011", IR);
    end
  endtask

  task automatic test_store_load();
    run_req(2'b10, 9'd5, 32'hDEAD_BEEF);
    run_req(2'b01, 9'd5, 32'h0);
    checks++;
    if (MDR !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL store_load: MDR=%h, expected deadbeef", MDR);
    end
  endtask

  task automatic test_reserved();
    run_req(2'b11, 9'd7, 32'hCAFE_F00D);
  endtask

  task automatic test_back_to_back();
    int acc_t [4];
    int n;
    bd_write(9'd21, 32'd31);
    bd_write(9'd22, 32'hFFFF_FFFB);
    @(negedge CLK);
    bus.REQ_VALID = 1'b1; bus.REQ_OP = 2'b00; bus.REQ_ADDR = 9'd21;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      if (bus.REQ_READY === 1'b1) begin
        acc_t[n] = cyc; n++;
        @(posedge CLK); #1;
        bus.REQ_OP = (n % 2 == 1) ? 2'b01 : 2'b00;
        bus.REQ_ADDR = (n % 2 == 1) ? 9'd22 : 9'd21;
        if (n == 4) bus.REQ_VALID = 1'b0;
      end
      @(negedge CLK);
    end
    repeat (6) @(negedge CLK);
    ref_ir = ref_mem[21]; ref_mdr = ref_mem[22]; ref_mra = 9'd22; ref_cnt = ref_cnt + 16'd4;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL b2b_accepts: got %0d accepts, expected 4", n);
    end else begin
      for (int j = 1; j < 4; j++) begin
        checks++;
        if (acc_t[j] - acc_t[j-1] != 4) begin
          errors++; $display("FAIL b2b_spacing %0d: got %0d cycles, expected 4", j, acc_t[j] - acc_t[j-1]);
        end
      end
    end
    checks++;
    if (IR !== 32'h0000_001F || MDR !== 32'hFFFF_FFFB || ACC_CNT !== ref_cnt) begin
      errors++; $display("FAIL b2b_regs: IR=%h MDR=%h CNT=%0d, expected 0000001f fffffffb %0d", IR, MDR, ACC_CNT, ref_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_req(2'($urandom_range(3, 0)), 9'($urandom_range(511, 0)), $urandom);
    end
  endtask

  task automatic test_reset_mid();
    int done_n;
    bd_write(9'd24, 32'd250);
    @(negedge CLK);
    bus.REQ_VALID = 1'b1; bus.REQ_OP = 2'b01; bus.REQ_ADDR = 9'd24;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    model_reset();
    checks++;
    if (MDR !== 32'h0 || IR !== 32'h0 || ACC_CNT !== 16'h0 || bus.REQ_READY !== 1'b1 || bus.MWE !== 1'b0) begin
      errors++; $display("FAIL reset_mid: MDR=%h IR=%h CNT=%0d READY=%b MWE=%b, expected 0 0 0 1 0", MDR, IR, ACC_CNT, bus.REQ_READY, bus.MWE);
    end
    done_n = 0;
    repeat (3) begin @(negedge CLK); if (bus.DONE === 1'b1) done_n++; end
    RST_N = 1'b1;
    repeat (4) begin @(negedge CLK); if (bus.DONE === 1'b1) done_n++; end
    checks++;
    if (done_n != 0 || MDR !== 32'h0 || bus.REQ_READY !== 1'b1) begin
      errors++; $display("FAIL reset_abort: DONE pulses %0d MDR=%h READY=%b, expected 0 0 1", done_n, MDR, bus.REQ_READY);
    end
    run_req(2'b01, 9'd24, 32'h0);
    checks++;
    if (MDR !== 32'h0000_00FA) begin
      errors++; $display("FAIL reload: MDR=%h, expected 000000fa", MDR);
    end
  endtask

  task automatic test_wrap();
    int nd;
    bit pend;
    @(negedge CLK);
    checks++;
    if (ACC_CNT2 !== 3'd0) begin
      errors++; $display("FAIL wrap_start: got %0d, expected 0", ACC_CNT2);
    end
    bus2.REQ_VALID = 1'b1; bus2.REQ_OP = 2'b00; bus2.REQ_ADDR = 9'd0;
    nd = 0; pend = 1'b0;
    for (int i = 0; i < 80 && (nd < 9 || pend); i++) begin
      @(negedge CLK);
      if (pend) begin
        pend = 1'b0;
        checks++;
        if (ACC_CNT2 !== 3'(nd)) begin
          errors++; $display("FAIL wrap_count after %0d: got %0d, expected %0d", nd, ACC_CNT2, 3'(nd));
        end
      end
      if (bus2.DONE === 1'b1) begin
        nd++; pend = 1'b1;
        if (nd == 9) bus2.REQ_VALID = 1'b0;
      end
    end
    bus2.REQ_VALID = 1'b0;
    checks++;
    if (nd != 9) begin
      errors++; $display("FAIL wrap_done: got %0d completions, expected 9", nd);
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_fetch();
    test_store_load();
    test_reserved();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
